// File: rtl/id_decode_pipe.sv
// id_decode_pipe: instruction decode stage. Holds the register file, decodes
// the IF instruction, detects load-use hazards against the instruction now in
// EXE, resolves branches and registers the decoded fields into ID/EXE.
//
// Optional feature (macro ID_WB_BYPASS_EN): when defined, a register read whose
// address matches an active write-back returns wb_data in the same cycle. When
// undefined, the read returns the value stored before that write.
//
// Handshake: instr_valid qualifies instr. While stall is high, IF must present
// the same instr/instr_valid again next cycle. valid_out qualifies the
// registered ID/EXE fields; with valid_out low they are a bubble.
//
// Opcode map (instr[31:26]) -> exe_cmd:
//   0 NOP, 1 ADD->1, 3 SUB->2, 5 AND->3, 6 OR->4, 7 NOR->5, 8 XOR->6,
//   9 SLA->7, 10 SLL->7, 11 SRA->8, 12 SRL->9, 32 ADDI->1, 33 SUBI->2,
//   36 LD->1, 37 ST->1, 40 BEZ, 41 BNE, 42 JMP (branches carry exe_cmd 0).
//   Unknown opcodes decode as NOP.
module id_decode_pipe #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic              flush,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_we,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] reg2,
    output logic [REG_AW-1:0] dest,
    output logic [3:0]        exe_cmd,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en,
    output logic              valid_out,
    output logic              stall,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_offset
);

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EZ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;
    localparam logic [1:0] BR_AL   = 2'b11;

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic [3:0]        c_exe_cmd;
    logic              c_mem_read;
    logic              c_mem_write;
    logic              c_wb_enable;
    logic              c_is_imm;
    logic [1:0]        c_branch;

    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dest_d;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              wb_hit;
    logic              br_cond;
    logic              issue;

    assign src1   = REG_AW'(instr[25:21]);
    assign src2   = REG_AW'(instr[20:16]);
    assign imm    = DATA_W'($signed(instr[15:0]));
    assign dest_d = c_is_imm ? REG_AW'(instr[20:16]) : REG_AW'(instr[15:11]);

    // A write-back only lands when it targets a real, non-zero register.
    assign wb_hit = wb_we && (wb_dest != '0) && (int'(wb_dest) < NUM_REGS);

    // Control unit: opcode to execution command and control flags.
    always_comb begin
        c_exe_cmd   = 4'd0;
        c_mem_read  = 1'b0;
        c_mem_write = 1'b0;
        c_wb_enable = 1'b0;
        c_is_imm    = 1'b0;
        c_branch    = BR_NONE;
        case (instr[31:26])
            OP_ADD:  begin c_exe_cmd = 4'd1; c_wb_enable = 1'b1; end
            OP_SUB:  begin c_exe_cmd = 4'd2; c_wb_enable = 1'b1; end
            OP_AND:  begin c_exe_cmd = 4'd3; c_wb_enable = 1'b1; end
            OP_OR:   begin c_exe_cmd = 4'd4; c_wb_enable = 1'b1; end
            OP_NOR:  begin c_exe_cmd = 4'd5; c_wb_enable = 1'b1; end
            OP_XOR:  begin c_exe_cmd = 4'd6; c_wb_enable = 1'b1; end
            OP_SLA,
            OP_SLL:  begin c_exe_cmd = 4'd7; c_wb_enable = 1'b1; end
            OP_SRA:  begin c_exe_cmd = 4'd8; c_wb_enable = 1'b1; end
            OP_SRL:  begin c_exe_cmd = 4'd9; c_wb_enable = 1'b1; end
            OP_ADDI: begin c_exe_cmd = 4'd1; c_wb_enable = 1'b1; c_is_imm = 1'b1; end
            OP_SUBI: begin c_exe_cmd = 4'd2; c_wb_enable = 1'b1; c_is_imm = 1'b1; end
            OP_LD:   begin c_exe_cmd = 4'd1; c_wb_enable = 1'b1; c_is_imm = 1'b1; c_mem_read = 1'b1; end
            OP_ST:   begin c_exe_cmd = 4'd1; c_is_imm = 1'b1; c_mem_write = 1'b1; end
            OP_BEZ:  begin c_branch = BR_EZ; c_is_imm = 1'b1; end
            OP_BNE:  begin c_branch = BR_NE; end
            OP_JMP:  begin c_branch = BR_AL; c_is_imm = 1'b1; end
            default: ;
        endcase
    end

    // Register file write port; register 0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_hit) begin
            rf[wb_dest] <= wb_data;
        end
    end

    // Register file read ports, optionally bypassing the write-back in flight.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (src1 != '0 && int'(src1) < NUM_REGS) rd1 = rf[src1];
        if (src2 != '0 && int'(src2) < NUM_REGS) rd2 = rf[src2];
`ifdef ID_WB_BYPASS_EN
        if (wb_hit && wb_dest == src1) rd1 = wb_data;
        if (wb_hit && wb_dest == src2) rd2 = wb_data;
`endif
    end

    // Load-use hazard against the load sitting in EXE; a flushed slot never stalls.
    assign stall = instr_valid && !flush && valid_out && mem_r_en && (dest != '0) &&
                   ((dest == src1) || ((dest == src2) && !c_is_imm));

    // Branch condition on the (possibly bypassed) read values.
    always_comb begin
        br_cond = 1'b0;
        case (c_branch)
            BR_EZ:   br_cond = (rd1 == '0);
            BR_NE:   br_cond = (rd1 != rd2);
            BR_AL:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken  = instr_valid && !stall && !flush && br_cond;
    assign br_offset = imm;
    assign issue     = instr_valid && !flush && !stall;

    // ID/EXE register: capture the decoded instruction or load a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val1      <= '0;
            val2      <= '0;
            reg2      <= '0;
            dest      <= '0;
            exe_cmd   <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en     <= 1'b0;
            valid_out <= 1'b0;
        end else if (issue) begin
            val1      <= rd1;
            val2      <= c_is_imm ? imm : rd2;
            reg2      <= rd2;
            dest      <= dest_d;
            exe_cmd   <= c_exe_cmd;
            mem_r_en  <= c_mem_read;
            mem_w_en  <= c_mem_write;
            wb_en     <= c_wb_enable;
            valid_out <= 1'b1;
        end else begin
            val1      <= '0;
            val2      <= '0;
            reg2      <= '0;
            dest      <= '0;
            exe_cmd   <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en     <= 1'b0;
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed bench for id_decode_pipe. A behavioural model of
// the decode stage (instruction classes, a model register file and an expected
// ID/EXE stage) is compared against the default-size DUT every cycle; literal
// expectations pin the model and a DATA_W=16 / NUM_REGS=8 instance.
`timescale 1ns/1ps
module tb_id_decode_pipe;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int S_DW     = 16;
    localparam int S_NR     = 8;
    localparam int S_AW     = $clog2(S_NR);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]       instr = '0;
    logic              instr_valid = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] wb_data = '0;
    logic [REG_AW-1:0] wb_dest = '0;
    logic              wb_we = 1'b0;

    logic [DATA_W-1:0] val1, val2, reg2, br_offset;
    logic [REG_AW-1:0] dest;
    logic [3:0]        exe_cmd;
    logic              mem_r_en, mem_w_en, wb_en, valid_out, stall, br_taken;

    logic [S_DW-1:0]   wb_data_s;
    logic [S_AW-1:0]   wb_dest_s;
    logic [S_DW-1:0]   val1_s, val2_s, reg2_s, br_offset_s;
    logic [S_AW-1:0]   dest_s;
    logic [3:0]        exe_cmd_s;
    logic              mem_r_en_s, mem_w_en_s, wb_en_s, valid_out_s, stall_s, br_taken_s;

    assign wb_data_s = wb_data[S_DW-1:0];
    assign wb_dest_s = wb_dest[S_AW-1:0];

    id_decode_pipe #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush),
        .wb_data(wb_data), .wb_dest(wb_dest), .wb_we(wb_we),
        .val1(val1), .val2(val2), .reg2(reg2), .dest(dest), .exe_cmd(exe_cmd),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .valid_out(valid_out),
        .stall(stall), .br_taken(br_taken), .br_offset(br_offset)
    );

    id_decode_pipe #(.DATA_W(S_DW), .NUM_REGS(S_NR)) u_dut_s (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush),
        .wb_data(wb_data_s), .wb_dest(wb_dest_s), .wb_we(wb_we),
        .val1(val1_s), .val2(val2_s), .reg2(reg2_s), .dest(dest_s), .exe_cmd(exe_cmd_s),
        .mem_r_en(mem_r_en_s), .mem_w_en(mem_w_en_s), .wb_en(wb_en_s), .valid_out(valid_out_s),
        .stall(stall_s), .br_taken(br_taken_s), .br_offset(br_offset_s)
    );

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum logic [2:0] {K_NONE, K_RALU, K_IALU, K_LOAD, K_STORE, K_BEZ, K_BNE, K_JMP} kind_t;

    typedef struct packed {
        logic              valid;
        logic              mr;
        logic              mw;
        logic              wb;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] reg2;
        logic [REG_AW-1:0] dest;
        logic [3:0]        cmd;
    } stage_t;
    localparam int STAGE_W = $bits(stage_t);

    logic [STAGE_W-1:0] exp_q[$];
    stage_t             m_stage = '0;
    stage_t             cur_exp = '0;
    logic [DATA_W-1:0]  m_rf [NUM_REGS];

    function automatic kind_t kind_of(input logic [5:0] op);
        case (int'(op))
            1, 3, 5, 6, 7, 8, 9, 10, 11, 12: return K_RALU;
            32, 33:  return K_IALU;
            36:      return K_LOAD;
            37:      return K_STORE;
            40:      return K_BEZ;
            41:      return K_BNE;
            42:      return K_JMP;
            default: return K_NONE;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op);
        case (int'(op))
            1, 32, 36, 37: return 4'd1;
            3, 33:   return 4'd2;
            5:       return 4'd3;
            6:       return 4'd4;
            7:       return 4'd5;
            8:       return 4'd6;
            9, 10:   return 4'd7;
            11:      return 4'd8;
            12:      return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic uses_imm(input kind_t k);
        return k inside {K_IALU, K_LOAD, K_STORE, K_BEZ, K_JMP};
    endfunction

    function automatic logic [DATA_W-1:0] m_read(input int a);
        int idx;
        idx = a % (1 << REG_AW);
        if (idx == 0 || idx >= NUM_REGS) return '0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && int'(wb_dest) == idx) return wb_data;
`endif
        return m_rf[idx];
    endfunction

    function automatic logic [DATA_W-1:0] m_off();
        int v;
        v = int'(instr[15:0]);
        if (v >= 32768) v = v - 65536;
        return DATA_W'(v);
    endfunction

    function automatic logic m_stall();
        int s1, s2, d;
        s1 = int'(instr[25:21]) % (1 << REG_AW);
        s2 = int'(instr[20:16]) % (1 << REG_AW);
        d  = int'(m_stage.dest);
        if (!instr_valid || flush) return 1'b0;
        if (!m_stage.valid || !m_stage.mr || d == 0) return 1'b0;
        return (d == s1) || (d == s2 && !uses_imm(kind_of(instr[31:26])));
    endfunction

    function automatic logic m_br();
        kind_t k;
        k = kind_of(instr[31:26]);
        if (!instr_valid || flush || m_stall()) return 1'b0;
        case (k)
            K_BEZ:   return m_read(int'(instr[25:21])) == '0;
            K_BNE:   return m_read(int'(instr[25:21])) != m_read(int'(instr[20:16]));
            K_JMP:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic stage_t model_next();
        stage_t n;
        kind_t  k;
        n = '0;
        k = kind_of(instr[31:26]);
        if (instr_valid && !flush && !m_stall()) begin
            n.valid = 1'b1;
            n.mr    = (k == K_LOAD);
            n.mw    = (k == K_STORE);
            n.wb    = k inside {K_RALU, K_IALU, K_LOAD};
            n.cmd   = alu_of(instr[31:26]);
            n.val1  = m_read(int'(instr[25:21]));
            n.reg2  = m_read(int'(instr[20:16]));
            n.val2  = uses_imm(k) ? m_off() : n.reg2;
            n.dest  = REG_AW'(uses_imm(k) ? instr[20:16] : instr[15:11]);
        end
        return n;
    endfunction

    // Model state advances on the same edges as the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stage <= '0;
            for (int i = 0; i < NUM_REGS; i++) m_rf[i] <= '0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_next());
            m_stage <= model_next();
            if (wb_we && wb_dest != '0 && int'(wb_dest) < NUM_REGS) m_rf[wb_dest] <= wb_data;
        end
    end

    // Scoreboard compare on the falling edge, every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                cur_exp = '0;
            end else begin
                if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                check("m_valid_out", valid_out, cur_exp.valid);
                check("m_mem_r_en", mem_r_en, cur_exp.mr);
                check("m_mem_w_en", mem_w_en, cur_exp.mw);
                check("m_wb_en", wb_en, cur_exp.wb);
                check("m_stall", stall, m_stall());
                check("m_br_taken", br_taken, m_br());
                check("m_br_offset", br_offset, m_off());
                if (cur_exp.valid) begin
                    check("m_val1", val1, cur_exp.val1);
                    check("m_val2", val2, cur_exp.val2);
                    check("m_reg2", reg2, cur_exp.reg2);
                    check("m_dest", dest, cur_exp.dest);
                    check("m_exe_cmd", exe_cmd, cur_exp.cmd);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [31:0] i, input logic v, input logic f, input logic we,
                         input logic [REG_AW-1:0] wd, input logic [DATA_W-1:0] wdat);
        @(posedge clk);
        #2;
        instr       = i;
        instr_valid = v;
        flush       = f;
        wb_we       = we;
        wb_dest     = wd;
        wb_data     = wdat;
    endtask

    task automatic idle();
        apply(32'd0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wb(input int r, input logic [DATA_W-1:0] d);
        apply(32'd0, 1'b0, 1'b0, 1'b1, REG_AW'(r), d);
    endtask

    task automatic issue(input logic [31:0] i, input logic f);
        apply(i, 1'b1, f, 1'b0, '0, '0);
    endtask

    function automatic logic [31:0] enc_r(input int op, input int s1, input int s2, input int d);
        return {6'(op), 5'(s1), 5'(s2), 5'(d), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int s1, input int d, input logic [15:0] im);
        return {6'(op), 5'(s1), 5'(d), im};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_out"}, valid_out, 0);
        check({tag, "_mem_r_en"}, mem_r_en, 0);
        check({tag, "_wb_en"}, wb_en, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_val1"}, val1, 0);
        check({tag, "_reg2"}, reg2, 0);
        check({tag, "_dest"}, dest, 0);
        check({tag, "_exe_cmd"}, exe_cmd, 0);
        check({tag, "_s_valid_out"}, valid_out_s, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst = 1'b0;
        #1 check_all_zero("rst0");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Write-back r3 then ADD r5 = r3 + r3.
        wb(3, 32'h1234);
        issue(enc_r(1, 3, 3, 5), 1'b0);
        idle();
        check("add_val1", val1, 32'h1234);
        check("add_reg2", reg2, 32'h1234);
        check("add_dest", dest, 5);
        check("add_exe_cmd", exe_cmd, 1);
        check("add_wb_en", wb_en, 1);
        check("s_add_val1", val1_s, 16'h1234);

        // Same-cycle write-back of r4 while reading r4.
        apply(enc_r(1, 4, 0, 6), 1'b1, 1'b0, 1'b1, 5'd4, 32'hAA);
        idle();
`ifdef ID_WB_BYPASS_EN
        check("bypass_val1", val1, 32'hAA);
        check("s_bypass_val1", val1_s, 16'hAA);
`else
        check("bypass_val1", val1, 32'h0);
        check("s_bypass_val1", val1_s, 16'h0);
`endif

        // Load-use on r7: one stall, bubble, then ADD issues.
        issue(enc_i(36, 0, 7, 16'd4), 1'b0);
        issue(enc_r(1, 7, 3, 8), 1'b0);
        #1 check("lu_stall", stall, 1);
        check("s_lu_stall", stall_s, 1);
        issue(enc_r(1, 7, 3, 8), 1'b0);
        check("lu_bubble_valid", valid_out, 0);
        check("lu_bubble_wb_en", wb_en, 0);
        #1 check("lu_stall_released", stall, 0);
        idle();
        check("lu_add_valid", valid_out, 1);
        check("lu_add_dest", dest, 8);
        check("lu_add_val2", val2, 32'h1234);

        // Load to r0 never stalls.
        issue(enc_i(36, 0, 0, 16'd4), 1'b0);
        issue(enc_r(1, 0, 3, 9), 1'b0);
        #1 check("lu_r0_stall", stall, 0);
        idle();
        check("lu_r0_valid", valid_out, 1);

        // Flush wins over a pending load-use stall.
        issue(enc_i(36, 0, 7, 16'd4), 1'b0);
        issue(enc_r(1, 7, 3, 8), 1'b1);
        #1 check("flush_stall", stall, 0);
        idle();
        check("flush_valid", valid_out, 0);

        // Branches: BNE r1=5 vs r2=6 taken, BNE r1,r1 not taken, flushed BNE not taken.
        wb(1, 32'd5);
        wb(2, 32'd6);
        issue(enc_i(41, 1, 2, 16'hFFFC), 1'b0);
        #1 check("bne_taken", br_taken, 1);
        check("bne_offset", br_offset, 32'hFFFF_FFFC);
        check("s_bne_taken", br_taken_s, 1);
        check("s_bne_offset", br_offset_s, 16'hFFFC);
        issue(enc_i(41, 1, 1, 16'hFFFC), 1'b0);
        check("bne_ex_valid", valid_out, 1);
        check("bne_ex_wb_en", wb_en, 0);
        check("bne_ex_mem_w_en", mem_w_en, 0);
        #1 check("bne_eq_taken", br_taken, 0);
        issue(enc_i(41, 1, 2, 16'hFFFC), 1'b1);
        #1 check("bne_flush_taken", br_taken, 0);
        idle();
        check("bne_flush_valid", valid_out, 0);

        // Source 9 aliases r1 in the 8-entry instance only.
        issue(enc_r(1, 9, 0, 10), 1'b0);
        idle();
        check("alias_val1", val1, 0);
        check("s_alias_val1", val1_s, 16'd5);

        // Reset asserted mid-cycle during a stall.
        issue(enc_i(36, 0, 7, 16'd4), 1'b0);
        issue(enc_r(1, 7, 3, 8), 1'b0);
        #1 check("rst_pre_stall", stall, 1);
        rst = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_post_stall", stall, 0);
        issue(enc_r(1, 3, 5, 12), 1'b0);
        check("rst_capture_valid", valid_out, 1);
        check("rst_capture_dest", dest, 8);
        idle();
        check("rst_r3_val1", val1, 0);
        check("rst_r5_reg2", reg2, 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
